// File: rtl/tpu_core_if.sv
// -----------------------------------------------------------------------------
// tpu_core_if -- bus bundle between a host and tpu_core.
//
// Signals (directions seen from the core, i.e. the slave modport):
//   load_weight  in   latch weight_in (IDLE only)
//   weight_in    in   N*N weights, w[r][c] at [(r*N+c)*DATA_W +: DATA_W]
//   accumulate   in   sampled with the first vector of a tile
//   in_valid     in   a_in carries a vector
//   in_ready     out  core accepts a vector
//   a_in         in   N activations, a[r] at [r*DATA_W +: DATA_W]
//   ub_rd_en     in   pop the oldest unified buffer word
//   ub_rd_data   out  popped word, column c at [c*ACC_W +: ACC_W]
//   ub_rd_valid  out  ub_rd_data valid for one cycle
//   ub_count     out  words held in the unified buffer
//   busy         out  core FSM not idle
//   tile_done    out  one-cycle pulse after a tile's last buffer write
// -----------------------------------------------------------------------------
interface tpu_core_if #(
    parameter int N        = 2,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 32,
    parameter int UB_DEPTH = 16
);
    localparam int CNT_W = $clog2(UB_DEPTH + 1);

    logic                      load_weight;
    logic [N*N*DATA_W-1:0]     weight_in;
    logic                      accumulate;
    logic                      in_valid;
    logic                      in_ready;
    logic [N*DATA_W-1:0]       a_in;
    logic                      ub_rd_en;
    logic [N*ACC_W-1:0]        ub_rd_data;
    logic                      ub_rd_valid;
    logic [CNT_W-1:0]          ub_count;
    logic                      busy;
    logic                      tile_done;

    modport master (
        output load_weight, weight_in, accumulate, in_valid, a_in, ub_rd_en,
        input  in_ready, ub_rd_data, ub_rd_valid, ub_count, busy, tile_done
    );

    modport slave (
        input  load_weight, weight_in, accumulate, in_valid, a_in, ub_rd_en,
        output in_ready, ub_rd_data, ub_rd_valid, ub_count, busy, tile_done
    );
endinterface

// File: rtl/tpu_core.sv
// -----------------------------------------------------------------------------
// tpu_core -- N x N weight-stationary systolic array with a ROWS-deep
// accumulator and a FIFO unified buffer for results.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high
//   core_if  tpu_core_if.slave bundle (weights, activations, buffer read port,
//            status)
//
// A tile is ROWS activation vectors. Row r of the array sees its input r
// cycles late and column c's result is delayed N-1-c cycles, so a vector
// accepted in cycle t lands in accumulator row k in cycle t+2N-1. After the
// last row is captured the accumulator is copied into the unified buffer one
// row per cycle.
//
// Build option: define TPU_CORE_SATURATE_EN to make the accumulate add
// saturate instead of wrapping.
// -----------------------------------------------------------------------------
module tpu_core #(
    parameter int N        = 2,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 32,
    parameter int ROWS     = 2,
    parameter int UB_DEPTH = 16
) (
    input  logic      clk,
    input  logic      reset,
    tpu_core_if.slave core_if
);
    localparam int CNT_W = $clog2(UB_DEPTH + 1);
    localparam int PTR_W = (UB_DEPTH > 1) ? $clog2(UB_DEPTH) : 1;
    localparam int RC_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LAT   = 2 * N - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_WRITE  = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic signed [DATA_W-1:0]   w_q      [N][N];
    logic                       weights_loaded_q;
    logic                       accum_q;
    logic [RC_W-1:0]            in_cnt_q, cap_cnt_q, wr_cnt_q;
    logic [LAT-1:0]             vld_pipe_q;
    logic signed [DATA_W-1:0]   skew_q   [N][N];
    logic signed [DATA_W-1:0]   a_pe_q   [N][N];
    logic signed [ACC_W-1:0]    psum_q   [N][N];
    logic signed [ACC_W-1:0]    deskew_q [N][N];
    logic signed [ACC_W-1:0]    acc_q    [ROWS][N];
    logic [N*ACC_W-1:0]         ub_mem   [UB_DEPTH];
    logic [PTR_W-1:0]           ub_wr_ptr_q, ub_rd_ptr_q;
    logic [CNT_W-1:0]           ub_count_q;
    logic [N*ACC_W-1:0]         ub_rd_data_q;
    logic                       ub_rd_valid_q;
    logic                       tile_done_q;

    logic                       in_ready_s, accept_s, ub_wr_s, ub_rd_s;
    logic                       last_in_s, last_cap_s, last_wr_s;
    logic signed [DATA_W-1:0]   a_left_s [N][N];
    logic signed [2*DATA_W-1:0] prod_s   [N][N];
    logic signed [ACC_W-1:0]    pe_sum_s [N][N];
    logic signed [ACC_W-1:0]    y_s      [N];
    logic [N*ACC_W-1:0]         wr_word_s;

    function automatic logic signed [ACC_W-1:0] acc_add(
        input logic signed [ACC_W-1:0] x,
        input logic signed [ACC_W-1:0] y
    );
`ifdef TPU_CORE_SATURATE_EN
        logic [ACC_W:0] sum;
        sum = {x[ACC_W-1], x} + {y[ACC_W-1], y};
        // The two top bits disagree exactly when the signed add overflowed.
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            acc_add = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            acc_add = sum[ACC_W-1:0];
        end
`else
        acc_add = x + y;
`endif
    endfunction

    // Handshake and end-of-phase decode
    always_comb begin
        // A new tile may only start when ROWS free buffer words are guaranteed.
        in_ready_s = weights_loaded_q &&
                     (((state_q == ST_IDLE) && (ub_count_q <= CNT_W'(UB_DEPTH - ROWS))) ||
                      (state_q == ST_STREAM));
        accept_s   = in_ready_s && core_if.in_valid;
        ub_wr_s    = (state_q == ST_WRITE);
        ub_rd_s    = core_if.ub_rd_en && (ub_count_q != {CNT_W{1'b0}});
        last_in_s  = (in_cnt_q == RC_W'(ROWS - 1));
        last_cap_s = vld_pipe_q[LAT-1] && (cap_cnt_q == RC_W'(ROWS - 1));
        last_wr_s  = (wr_cnt_q == RC_W'(ROWS - 1));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = (ROWS == 1) ? ST_DRAIN : ST_STREAM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (accept_s && last_in_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (last_cap_s) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_WRITE: begin
                if (last_wr_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // PE operand routing, per-PE partial sums, deskewed column results
    always_comb begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (c > 0) begin
                    a_left_s[r][c] = a_pe_q[r][(c > 0) ? c - 1 : 0];
                end else if (r > 0) begin
                    a_left_s[r][c] = skew_q[r][(r > 0) ? r - 1 : 0];
                end else begin
                    a_left_s[r][c] = $signed(core_if.a_in[DATA_W-1:0]);
                end
                prod_s[r][c] = a_left_s[r][c] * w_q[r][c];
                if (r > 0) begin
                    pe_sum_s[r][c] = psum_q[(r > 0) ? r - 1 : 0][c] + ACC_W'(prod_s[r][c]);
                end else begin
                    pe_sum_s[r][c] = ACC_W'(prod_s[r][c]);
                end
            end
        end
        for (int c = 0; c < N; c++) begin
            // The last column leaves the array latest, so it needs no deskew.
            if (c == N - 1) begin
                y_s[c] = psum_q[N-1][c];
            end else begin
                y_s[c] = deskew_q[c][(c < N - 1) ? N - 2 - c : 0];
            end
        end
        wr_word_s = {(N*ACC_W){1'b0}};
        for (int c = 0; c < N; c++) begin
            wr_word_s[c*ACC_W +: ACC_W] = acc_q[wr_cnt_q][c];
        end
    end

    // FSM state, weights, tile counters and accumulator capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            weights_loaded_q <= 1'b0;
            accum_q          <= 1'b0;
            in_cnt_q         <= {RC_W{1'b0}};
            cap_cnt_q        <= {RC_W{1'b0}};
            wr_cnt_q         <= {RC_W{1'b0}};
            vld_pipe_q       <= {LAT{1'b0}};
            tile_done_q      <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    w_q[r][c] <= {DATA_W{1'b0}};
                end
            end
            for (int k = 0; k < ROWS; k++) begin
                for (int c = 0; c < N; c++) begin
                    acc_q[k][c] <= {ACC_W{1'b0}};
                end
            end
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && core_if.load_weight) begin
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        w_q[r][c] <= $signed(core_if.weight_in[(r*N+c)*DATA_W +: DATA_W]);
                    end
                end
                weights_loaded_q <= 1'b1;
            end
            if (accept_s) begin
                if (state_q == ST_IDLE) begin
                    accum_q  <= core_if.accumulate;
                    in_cnt_q <= RC_W'(1);
                end else begin
                    in_cnt_q <= in_cnt_q + RC_W'(1);
                end
            end
            // One valid bit per accepted vector tracks it through the array.
            vld_pipe_q[0] <= accept_s;
            for (int i = 1; i < LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
            end
            if (vld_pipe_q[LAT-1]) begin
                for (int c = 0; c < N; c++) begin
                    acc_q[cap_cnt_q][c] <= accum_q ? acc_add(acc_q[cap_cnt_q][c], y_s[c]) : y_s[c];
                end
                cap_cnt_q <= last_cap_s ? {RC_W{1'b0}} : cap_cnt_q + RC_W'(1);
            end
            if (ub_wr_s) begin
                wr_cnt_q <= last_wr_s ? {RC_W{1'b0}} : wr_cnt_q + RC_W'(1);
            end
            tile_done_q <= ub_wr_s && last_wr_s;
        end
    end

    // Systolic datapath: input skew chains, PE registers, output deskew chains
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    skew_q[i][j]   <= {DATA_W{1'b0}};
                    a_pe_q[i][j]   <= {DATA_W{1'b0}};
                    psum_q[i][j]   <= {ACC_W{1'b0}};
                    deskew_q[i][j] <= {ACC_W{1'b0}};
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                skew_q[i][0]   <= $signed(core_if.a_in[i*DATA_W +: DATA_W]);
                deskew_q[i][0] <= psum_q[N-1][i];
                for (int j = 1; j < N; j++) begin
                    skew_q[i][j]   <= skew_q[i][j-1];
                    deskew_q[i][j] <= deskew_q[i][j-1];
                end
                for (int j = 0; j < N; j++) begin
                    a_pe_q[i][j] <= a_left_s[i][j];
                    psum_q[i][j] <= pe_sum_s[i][j];
                end
            end
        end
    end

    // Unified buffer pointers, occupancy and registered read port
    always_ff @(posedge clk) begin
        if (reset) begin
            ub_wr_ptr_q   <= {PTR_W{1'b0}};
            ub_rd_ptr_q   <= {PTR_W{1'b0}};
            ub_count_q    <= {CNT_W{1'b0}};
            ub_rd_data_q  <= {(N*ACC_W){1'b0}};
            ub_rd_valid_q <= 1'b0;
        end else begin
            if (ub_wr_s) begin
                ub_wr_ptr_q <= (ub_wr_ptr_q == PTR_W'(UB_DEPTH - 1)) ? {PTR_W{1'b0}} : ub_wr_ptr_q + PTR_W'(1);
            end
            if (ub_rd_s) begin
                ub_rd_ptr_q  <= (ub_rd_ptr_q == PTR_W'(UB_DEPTH - 1)) ? {PTR_W{1'b0}} : ub_rd_ptr_q + PTR_W'(1);
                ub_rd_data_q <= ub_mem[ub_rd_ptr_q];
            end
            ub_rd_valid_q <= ub_rd_s;
            case ({ub_wr_s, ub_rd_s})
                2'b10:   ub_count_q <= ub_count_q + CNT_W'(1);
                2'b01:   ub_count_q <= ub_count_q - CNT_W'(1);
                default: ub_count_q <= ub_count_q;
            endcase
        end
    end

    // Unified buffer storage; contents are qualified by the pointers, so no reset
    always_ff @(posedge clk) begin
        if (ub_wr_s) begin
            ub_mem[ub_wr_ptr_q] <= wr_word_s;
        end
    end

    assign core_if.in_ready    = in_ready_s;
    assign core_if.busy        = (state_q != ST_IDLE);
    assign core_if.tile_done   = tile_done_q;
    assign core_if.ub_rd_data  = ub_rd_data_q;
    assign core_if.ub_rd_valid = ub_rd_valid_q;
    assign core_if.ub_count    = ub_count_q;
endmodule

// File: tb/tb_tpu_core.sv
`timescale 1ns/1ps
module tb_tpu_core;
    localparam int N        = 2;
    localparam int DATA_W   = 16;
    localparam int ACC_W    = 32;
    localparam int ROWS     = 2;
    localparam int UB_DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tpu_core_if #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .UB_DEPTH(UB_DEPTH)) core_if ();

    tpu_core #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .ROWS(ROWS), .UB_DEPTH(UB_DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .core_if (core_if)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [N*ACC_W-1:0] exp_q [$];
    longint w_m   [N][N];
    longint acc_m [ROWS][N];
    longint vec_m [ROWS][N];

    function automatic longint wrap32(input longint v);
        logic signed [31:0] t;
        t = v[31:0];
        return longint'(t);
    endfunction

    function automatic longint sat32(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        else if (v < -64'sd2147483648) return -64'sd2147483648;
        else return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference matrix product and accumulate; pushes the expected buffer words
    task automatic model_tile(input bit acc_flag);
        longint y, s;
        logic [N*ACC_W-1:0] word;
        for (int k = 0; k < ROWS; k++) begin
            word = '0;
            for (int c = 0; c < N; c++) begin
                y = 0;
                for (int r = 0; r < N; r++) y += vec_m[k][r] * w_m[r][c];
                y = wrap32(y);
                if (acc_flag) begin
`ifdef TPU_CORE_SATURATE_EN
                    s = sat32(acc_m[k][c] + y);
`else
                    s = wrap32(acc_m[k][c] + y);
`endif
                end else begin
                    s = y;
                end
                acc_m[k][c] = s;
                word[c*ACC_W +: ACC_W] = s[ACC_W-1:0];
            end
            exp_q.push_back(word);
        end
    endtask

    task automatic load_weights();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                core_if.weight_in[(r*N+c)*DATA_W +: DATA_W] = w_m[r][c][DATA_W-1:0];
        core_if.load_weight = 1'b1;
        tick();
        core_if.load_weight = 1'b0;
    endtask

    task automatic drive_tile(input bit acc_flag);
        int waited;
        core_if.accumulate = acc_flag;
        for (int k = 0; k < ROWS; k++) begin
            for (int r = 0; r < N; r++) core_if.a_in[r*DATA_W +: DATA_W] = vec_m[k][r][DATA_W-1:0];
            core_if.in_valid = 1'b1;
            waited = 0;
            while (core_if.in_ready !== 1'b1 && waited < 200) begin
                tick();
                waited++;
            end
            if (waited >= 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, expected 1", core_if.in_ready, waited);
            end
            tick();
        end
        core_if.in_valid = 1'b0;
        model_tile(acc_flag);
    endtask

    task automatic wait_done(output int pulses);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (core_if.tile_done === 1'b1) pulses++;
        end
    endtask

    task automatic read_one(output logic v, output logic [N*ACC_W-1:0] d);
        core_if.ub_rd_en = 1'b1;
        tick();
        core_if.ub_rd_en = 1'b0;
        v = core_if.ub_rd_valid;
        d = core_if.ub_rd_data;
    endtask

    task automatic set_vec(input int k, input longint a0, input longint a1);
        vec_m[k][0] = a0;
        vec_m[k][1] = a1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        foreach (acc_m[k, c]) acc_m[k][c] = 0;
        exp_q.delete();
        n_cmp++; if (core_if.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b expected 0", core_if.in_ready); end
        n_cmp++; if (core_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", core_if.busy); end
        n_cmp++; if (core_if.tile_done !== 1'b0) begin n_err++; $display("FAIL reset_tile_done: got %b expected 0", core_if.tile_done); end
        n_cmp++; if (core_if.ub_rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b expected 0", core_if.ub_rd_valid); end
        n_cmp++; if (core_if.ub_count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", core_if.ub_count); end
        n_cmp++; if (core_if.ub_rd_data !== 64'd0) begin n_err++; $display("FAIL reset_rd_data: got %h expected 0", core_if.ub_rd_data); end
    endtask

    task automatic test_basic();
        int p;
        logic v;
        logic [N*ACC_W-1:0] d, e;
        w_m[0][0] = 1; w_m[0][1] = 2; w_m[1][0] = 3; w_m[1][1] = 4;
        load_weights();
        n_cmp++; if (core_if.in_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_after_load: got %b expected 1", core_if.in_ready); end
        set_vec(0, 1, 2);
        set_vec(1, 3, 4);
        drive_tile(1'b0);
        wait_done(p);
        n_cmp++; if (p !== 1) begin n_err++; $display("FAIL basic_tile_done_pulses: got %0d expected 1", p); end
        n_cmp++; if (core_if.ub_count !== 5'd2) begin n_err++; $display("FAIL basic_count: got %0d expected 2", core_if.ub_count); end
        read_one(v, d);
        e = exp_q.pop_front();
        n_cmp++; if (v !== 1'b1 || d !== 64'h0000000A_00000007 || d !== e) begin n_err++; $display("FAIL basic_word0: got v=%b %h expected v=1 %h", v, d, 64'h0000000A_00000007); end
        read_one(v, d);
        e = exp_q.pop_front();
        n_cmp++; if (v !== 1'b1 || d !== 64'h00000016_0000000F || d !== e) begin n_err++; $display("FAIL basic_word1: got v=%b %h expected v=1 %h", v, d, 64'h00000016_0000000F); end
    endtask

    task automatic test_accumulate();
        int p;
        logic v;
        logic [N*ACC_W-1:0] d, e;
        drive_tile(1'b1);
        drive_tile(1'b0);
        wait_done(p);
        n_cmp++; if (core_if.ub_count !== 5'd4) begin n_err++; $display("FAIL acc_count: got %0d expected 4", core_if.ub_count); end
        while (exp_q.size() > 0) begin
            read_one(v, d);
            e = exp_q.pop_front();
            n_cmp++; if (v !== 1'b1 || d !== e) begin n_err++; $display("FAIL acc_word: got v=%b %h expected v=1 %h", v, d, e); end
        end
    endtask

    task automatic test_back_to_back();
        int p;
        logic v;
        logic signed [15:0] t;
        logic [N*ACC_W-1:0] d, e;
        for (int tile = 0; tile < 8; tile++) begin
            for (int k = 0; k < ROWS; k++)
                for (int r = 0; r < N; r++) begin
                    t = 16'($urandom);
                    vec_m[k][r] = longint'(t);
                end
            drive_tile(1'($urandom_range(0, 1)));
        end
        wait_done(p);
        n_cmp++; if (core_if.ub_count !== 5'd16) begin n_err++; $display("FAIL full_count: got %0d expected 16", core_if.ub_count); end
        n_cmp++; if (core_if.in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b expected 0", core_if.in_ready); end
        read_one(v, d);
        e = exp_q.pop_front();
        n_cmp++; if (v !== 1'b1 || d !== e) begin n_err++; $display("FAIL full_word: got v=%b %h expected v=1 %h", v, d, e); end
        n_cmp++; if (core_if.in_ready !== 1'b0) begin n_err++; $display("FAIL ready_15: got %b expected 0", core_if.in_ready); end
        read_one(v, d);
        e = exp_q.pop_front();
        n_cmp++; if (core_if.in_ready !== 1'b1) begin n_err++; $display("FAIL ready_14: got %b expected 1", core_if.in_ready); end
        n_cmp++; if (v !== 1'b1 || d !== e) begin n_err++; $display("FAIL full_word: got v=%b %h expected v=1 %h", v, d, e); end
        while (exp_q.size() > 0) begin
            read_one(v, d);
            e = exp_q.pop_front();
            n_cmp++; if (v !== 1'b1 || d !== e) begin n_err++; $display("FAIL full_word: got v=%b %h expected v=1 %h", v, d, e); end
        end
    endtask

    task automatic test_ub_edges();
        int p, waited;
        logic v;
        logic [N*ACC_W-1:0] d, e;
        read_one(v, d);
        n_cmp++; if (v !== 1'b0) begin n_err++; $display("FAIL empty_read_valid: got %b expected 0", v); end
        n_cmp++; if (core_if.ub_count !== 5'd0) begin n_err++; $display("FAIL empty_read_count: got %0d expected 0", core_if.ub_count); end
        set_vec(0, 5, -6);
        set_vec(1, -7, 8);
        drive_tile(1'b0);
        wait_done(p);
        drive_tile(1'b0);
        waited = 0;
        while (core_if.ub_count !== 5'd3 && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) begin n_cmp++; n_err++; $display("FAIL write_wait_timeout: count=%0d expected 3", core_if.ub_count); end
        // Now in the second write cycle: read and write share the next edge.
        read_one(v, d);
        e = exp_q.pop_front();
        n_cmp++; if (core_if.ub_count !== 5'd3) begin n_err++; $display("FAIL rw_count: got %0d expected 3", core_if.ub_count); end
        n_cmp++; if (v !== 1'b1 || d !== e) begin n_err++; $display("FAIL rw_word: got v=%b %h expected v=1 %h", v, d, e); end
        n_cmp++; if (core_if.tile_done !== 1'b1) begin n_err++; $display("FAIL rw_tile_done: got %b expected 1", core_if.tile_done); end
        while (exp_q.size() > 0) begin
            read_one(v, d);
            e = exp_q.pop_front();
            n_cmp++; if (v !== 1'b1 || d !== e) begin n_err++; $display("FAIL rw_drain_word: got v=%b %h expected v=1 %h", v, d, e); end
        end
    endtask

    task automatic test_reset_in_drain();
        int p;
        drive_tile(1'b0);
        wait_done(p);
        drive_tile(1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        foreach (acc_m[k, c]) acc_m[k][c] = 0;
        n_cmp++; if (core_if.busy !== 1'b0) begin n_err++; $display("FAIL drain_reset_busy: got %b expected 0", core_if.busy); end
        n_cmp++; if (core_if.ub_count !== 5'd0) begin n_err++; $display("FAIL drain_reset_count: got %0d expected 0", core_if.ub_count); end
        n_cmp++; if (core_if.in_ready !== 1'b0) begin n_err++; $display("FAIL drain_reset_ready: got %b expected 0", core_if.in_ready); end
        wait_done(p);
        n_cmp++; if (p !== 0) begin n_err++; $display("FAIL drain_reset_tile_done: got %0d pulses expected 0", p); end
        n_cmp++; if (core_if.in_ready !== 1'b0) begin n_err++; $display("FAIL drain_reset_ready_later: got %b expected 0", core_if.in_ready); end
        load_weights();
        n_cmp++; if (core_if.in_ready !== 1'b1) begin n_err++; $display("FAIL reload_ready: got %b expected 1", core_if.in_ready); end
    endtask

    task automatic test_saturate();
        int p, idx;
        logic v;
        logic [N*ACC_W-1:0] d, e;
        logic [31:0] sat_exp;
`ifdef TPU_CORE_SATURATE_EN
        sat_exp = 32'h7FFFFFFF;
`else
        sat_exp = 32'h80000010;
`endif
        w_m[0][0] = -32768; w_m[0][1] = 0; w_m[1][0] = 1; w_m[1][1] = 0;
        load_weights();
        set_vec(0, -32768, -16); set_vec(1, 0, 0);
        drive_tile(1'b0);
        set_vec(0, -32768, 0);
        drive_tile(1'b1);
        set_vec(0, 0, 32);
        drive_tile(1'b1);
        wait_done(p);
        n_cmp++; if (core_if.ub_count !== 5'd6) begin n_err++; $display("FAIL sat_count: got %0d expected 6", core_if.ub_count); end
        idx = 0;
        while (exp_q.size() > 0) begin
            read_one(v, d);
            e = exp_q.pop_front();
            n_cmp++; if (v !== 1'b1 || d !== e) begin n_err++; $display("FAIL sat_word: got v=%b %h expected v=1 %h", v, d, e); end
            if (idx == 2) begin
                n_cmp++; if (d[31:0] !== 32'h7FFFFFF0) begin n_err++; $display("FAIL sat_pre: got %h expected 7ffffff0", d[31:0]); end
            end
            if (idx == 4) begin
                n_cmp++; if (d[31:0] !== sat_exp) begin n_err++; $display("FAIL sat_result: got %h expected %h", d[31:0], sat_exp); end
            end
            idx++;
        end
    endtask

    initial begin
        reset = 1'b1;
        core_if.load_weight = 1'b0;
        core_if.weight_in   = '0;
        core_if.accumulate  = 1'b0;
        core_if.in_valid    = 1'b0;
        core_if.a_in        = '0;
        core_if.ub_rd_en    = 1'b0;
        test_reset();
        test_basic();
        test_accumulate();
        test_back_to_back();
        test_ub_edges();
        test_reset_in_drain();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
